// File: rtl/mcpu_ctrl_pkg.sv
// Purpose: shared definitions for the multi-cycle CPU control and datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encodings, opcode/func codes, ALU_Control codes, mux selects.
package mcpu_defs;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_WBL = 4'd4,
    S_MWR = 4'd5,
    S_EXR = 4'd6,
    S_WBR = 4'd7,
    S_BR  = 4'd8,
    S_J   = 4'd9,
    S_EXI = 4'd10,
    S_WBI = 4'd11,
    S_INT = 4'd13
  } state_t;

  // Which ALU decode applies in the current state.
  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_IMM,
    CLS_BRANCH
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_LUI     = 2'b10;
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_A      = 1'b1;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;
  localparam logic       EXT_SIGN    = 1'b0;
  localparam logic       EXT_ZERO    = 1'b1;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_VEC    = 2'b11;

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Purpose: bundle between the control FSM (master) and the datapath (slave).
// Latency: n/a (wires only).
// Backpressure: MIO_ready from memory/IO stretches the memory states.
// Signals: IR fields, flags and INT in; every mux select / write enable out.
interface mcpu_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       MIO_ready;
  logic       INT;
  logic       PC_en;
  logic       IorD;
  logic       mem_r;
  logic       mem_w;
  logic       CPU_MIO;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtSel;
  logic [2:0] ALU_Control;
  logic [1:0] PCSource;
  logic       EPCWrite;
  logic [3:0] state;

  modport master (
    input  opcode, func, zero, MIO_ready, INT,
    output PC_en, IorD, mem_r, mem_w, CPU_MIO, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtSel, ALU_Control, PCSource, EPCWrite, state
  );

  modport slave (
    output opcode, func, zero, MIO_ready, INT,
    input  PC_en, IorD, mem_r, mem_w, CPU_MIO, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ExtSel, ALU_Control, PCSource, EPCWrite, state
  );
endinterface

// File: rtl/mcpu_ctrl_alu_dec.sv
// Purpose: ALU operation / extension decode from opcode, func and state class.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode, func, cls in; alu_ctrl, ext_sel, func_valid out.
module mcpu_alu_dec
  import mcpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  alu_cls_t   cls,
  output logic [2:0] alu_ctrl,
  output logic       ext_sel,
  output logic       func_valid
);

  always_comb begin
    alu_ctrl   = ALU_ADD;
    ext_sel    = EXT_SIGN;
    func_valid = 1'b0;
    case (cls)
      CLS_RTYPE: begin
        func_valid = 1'b1;
        case (func)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_XOR:   alu_ctrl = ALU_XOR;
          F_NOR:   alu_ctrl = ALU_NOR;
          F_SLT:   alu_ctrl = ALU_SLT;
          default: func_valid = 1'b0;
        endcase
      end
      CLS_IMM: begin
        // logical immediates zero-extend, arithmetic ones sign-extend
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: begin alu_ctrl = ALU_AND; ext_sel = EXT_ZERO; end
          OP_ORI:  begin alu_ctrl = ALU_OR;  ext_sel = EXT_ZERO; end
          OP_XORI: begin alu_ctrl = ALU_XOR; ext_sel = EXT_ZERO; end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Purpose: multi-cycle control FSM (IF/ID/EX/MEM/WB) with edge-triggered INT servicing.
// Latency: 3-5 cycles per instruction, plus one per MIO_ready=0 cycle in IF/MRD/MWR.
// Backpressure: memory states hold (outputs held) while MIO_ready=0 when WAIT_MEM=1.
// Ports: clk, reset (async, active-high), bus (mcpu_ctrl_if.master).
module mcpu_ctrl
  import mcpu_defs::*;
#(
  parameter bit WAIT_MEM   = 1'b1,
  parameter bit INT_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  mcpu_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       int_q, pending_q, pending_d, int_rise, mio_rdy;
  alu_cls_t   cls;
  logic [2:0] dec_alu;
  logic       dec_ext, func_valid;

  logic       pc_en, iord, mem_r, mem_w, ir_write, reg_write, src_a, ext, epc_write;
  logic [1:0] reg_dst, mem_to_reg, src_b, pc_src;
  logic [2:0] alu;

  assign mio_rdy  = WAIT_MEM ? bus.MIO_ready : 1'b1;
  assign int_rise = INT_ENABLE && bus.INT && !int_q;
  // A new edge wins over the clear in S_INT so a back-to-back request is kept.
  assign pending_d = INT_ENABLE && (int_rise || (pending_q && state_q != S_INT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      int_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_q     <= bus.INT;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    cls = CLS_NONE;
    case (state_q)
      S_EXR:   cls = CLS_RTYPE;
      S_EXI:   cls = CLS_IMM;
      S_BR:    cls = CLS_BRANCH;
      default: cls = CLS_NONE;
    endcase
  end

  mcpu_alu_dec u_alu_dec (
    .opcode     (bus.opcode),
    .func       (bus.func),
    .cls        (cls),
    .alu_ctrl   (dec_alu),
    .ext_sel    (dec_ext),
    .func_valid (func_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = ADDR_PC;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_B;
    ext        = EXT_SIGN;
    alu        = ALU_ADD;
    pc_src     = PCSRC_ALU;
    epc_write  = 1'b0;
    case (state_q)
      S_IF: begin
        if (pending_q) begin
          state_d = S_INT;  // take the interrupt instead of fetching
        end else begin
          mem_r    = 1'b1;
          iord     = ADDR_PC;
          src_a    = SRCA_PC;
          src_b    = SRCB_4;
          pc_src   = PCSRC_ALU;
          ir_write = mio_rdy;
          pc_en    = mio_rdy;
          if (mio_rdy) state_d = S_ID;
        end
      end
      S_ID: begin
        src_a = SRCA_PC;
        src_b = SRCB_BRANCH;  // precompute branch target into ALUOut
        case (bus.opcode)
          OP_RTYPE:                                 state_d = S_EXR;
          OP_LW, OP_SW:                             state_d = S_MA;
          OP_BEQ, OP_BNE:                           state_d = S_BR;
          OP_J:                                     state_d = S_J;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXI;
          OP_LUI:                                   state_d = S_WBI;
          default:                                  state_d = S_IF;
        endcase
      end
      S_MA: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        ext     = EXT_SIGN;
        state_d = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_r = 1'b1;
        iord  = ADDR_ALUOUT;
        if (mio_rdy) state_d = S_WBL;
      end
      S_WBL: begin
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        state_d    = S_IF;
      end
      S_MWR: begin
        mem_w = 1'b1;
        iord  = ADDR_ALUOUT;
        if (mio_rdy) state_d = S_IF;
      end
      S_EXR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_B;
        alu     = dec_alu;
        state_d = func_valid ? S_WBR : S_IF;  // unknown func retires as a nop
      end
      S_WBR: begin
        reg_dst    = REGDST_RD;
        mem_to_reg = M2R_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_IF;
      end
      S_BR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_B;
        alu     = dec_alu;
        pc_src  = PCSRC_ALUOUT;
        pc_en   = bus.zero ^ (bus.opcode == OP_BNE);
        state_d = S_IF;
      end
      S_J: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_IF;
      end
      S_EXI: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        alu     = dec_alu;
        ext     = dec_ext;
        state_d = S_WBI;
      end
      S_WBI: begin
        reg_dst    = REGDST_RT;
        reg_write  = 1'b1;
        mem_to_reg = (bus.opcode == OP_LUI) ? M2R_LUI : M2R_ALUOUT;
        state_d    = S_IF;
      end
      S_INT: begin
        epc_write = 1'b1;
        pc_src    = PCSRC_VEC;
        pc_en     = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Write/access strobes are suppressed for as long as reset is held.
  assign bus.PC_en       = pc_en & ~reset;
  assign bus.IRWrite     = ir_write & ~reset;
  assign bus.RegWrite    = reg_write & ~reset;
  assign bus.mem_r       = mem_r & ~reset;
  assign bus.mem_w       = mem_w & ~reset;
  assign bus.CPU_MIO     = (mem_r | mem_w) & ~reset;
  assign bus.EPCWrite    = epc_write & ~reset;
  assign bus.IorD        = iord;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.ExtSel      = ext;
  assign bus.ALU_Control = alu;
  assign bus.PCSource    = pc_src;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Purpose: self-checking bench for mcpu_ctrl against a per-instruction step model.
// Latency: n/a.
// Backpressure: MIO_ready stalls are scheduled by the model.
module tb_mcpu_ctrl;

  localparam int ST_IF = 0, ST_ID = 1, ST_MA = 2, ST_MRD = 3, ST_WBL = 4, ST_MWR = 5;
  localparam int ST_EXR = 6, ST_WBR = 7, ST_BR = 8, ST_J = 9, ST_EXI = 10, ST_WBI = 11;
  localparam int ST_INT = 13;

  // rdy: 0/1 = MIO_ready forced, 2 = don't care (randomised)
  typedef struct {
    int st;
    int rdy;
    bit rw, mw, mr, pce, irw, epc, intv, ext;
    int alu;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mw_seen = 0;
  step_t exp_q[$];

  mcpu_ctrl_if bus ();

  mcpu_ctrl #(.WAIT_MEM(1'b1), .INT_ENABLE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ALU operation an instruction should request in its execute step.
  function automatic int alu_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 2;
        6'h22: return 6;
        6'h24: return 0;
        6'h25: return 1;
        6'h26: return 3;
        6'h27: return 4;
        6'h2a: return 7;
        default: return 2;
      endcase
    end
    case (op)
      6'h0a: return 7;
      6'h0c: return 0;
      6'h0d: return 1;
      6'h0e: return 3;
      6'h04, 6'h05: return 6;
      default: return 2;
    endcase
  endfunction

  function automatic bit rfunc_ok(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
  endfunction

  function automatic step_t mk(input int st, input int rdy);
    step_t s;
    s.st = st; s.rdy = rdy;
    s.rw = 0; s.mw = 0; s.mr = 0; s.pce = 0; s.irw = 0; s.epc = 0; s.intv = 0; s.ext = 0;
    s.alu = 2;
    return s;
  endfunction

  // Expected cycle-by-cycle walk of one instruction, stalls included.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int if_st, input int mem_st);
    step_t s;
    exp_q.delete();
    for (int i = 0; i < if_st; i++) begin
      s = mk(ST_IF, 0); s.mr = 1; exp_q.push_back(s);
    end
    s = mk(ST_IF, 1); s.mr = 1; s.pce = 1; s.irw = 1; exp_q.push_back(s);
    exp_q.push_back(mk(ST_ID, 2));
    case (op)
      6'h00: begin
        s = mk(ST_EXR, 2); s.alu = alu_of(op, fn); exp_q.push_back(s);
        if (rfunc_ok(fn)) begin s = mk(ST_WBR, 2); s.rw = 1; exp_q.push_back(s); end
      end
      6'h23: begin
        exp_q.push_back(mk(ST_MA, 2));
        for (int i = 0; i < mem_st; i++) begin s = mk(ST_MRD, 0); s.mr = 1; exp_q.push_back(s); end
        s = mk(ST_MRD, 1); s.mr = 1; exp_q.push_back(s);
        s = mk(ST_WBL, 2); s.rw = 1; exp_q.push_back(s);
      end
      6'h2b: begin
        exp_q.push_back(mk(ST_MA, 2));
        for (int i = 0; i < mem_st; i++) begin s = mk(ST_MWR, 0); s.mw = 1; exp_q.push_back(s); end
        s = mk(ST_MWR, 1); s.mw = 1; exp_q.push_back(s);
      end
      6'h04, 6'h05: begin
        s = mk(ST_BR, 2); s.alu = 6; s.pce = z ^ (op == 6'h05); exp_q.push_back(s);
      end
      6'h02: begin s = mk(ST_J, 2); s.pce = 1; exp_q.push_back(s); end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: begin
        s = mk(ST_EXI, 2); s.alu = alu_of(op, fn); s.ext = (op >= 6'h0c); exp_q.push_back(s);
        s = mk(ST_WBI, 2); s.rw = 1; exp_q.push_back(s);
      end
      6'h0f: begin s = mk(ST_WBI, 2); s.rw = 1; exp_q.push_back(s); end
      default: ;
    endcase
  endtask

  task automatic run_q(input logic [5:0] op, input logic [5:0] fn, input bit z, input int nsteps);
    for (int k = 0; k < nsteps && k < exp_q.size(); k++) begin
      step_t s;
      s = exp_q[k];
      @(negedge clk);
      if (k == 0) begin bus.opcode = op; bus.func = fn; bus.zero = z; end
      bus.MIO_ready = (s.rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(s.rdy);
      bus.INT = s.intv;
      #1;
      chk("state", 32'(bus.state), s.st);
      chk("RegWrite", 32'(bus.RegWrite), 32'(s.rw));
      chk("mem_w", 32'(bus.mem_w), 32'(s.mw));
      chk("mem_r", 32'(bus.mem_r), 32'(s.mr));
      chk("CPU_MIO", 32'(bus.CPU_MIO), 32'(s.mr | s.mw));
      chk("PC_en", 32'(bus.PC_en), 32'(s.pce));
      chk("IRWrite", 32'(bus.IRWrite), 32'(s.irw));
      chk("ALU_Control", 32'(bus.ALU_Control), s.alu);
      chk("ExtSel", 32'(bus.ExtSel), 32'(s.ext));
      chk("EPCWrite", 32'(bus.EPCWrite), 32'(s.st == ST_INT));
      if (s.st == ST_IF && s.mr) begin
        chk("IF_IorD", 32'(bus.IorD), 0);
        chk("IF_PCSource", 32'(bus.PCSource), 0);
      end
      if (s.st == ST_MRD || s.st == ST_MWR) chk("mem_IorD", 32'(bus.IorD), 1);
      if (s.st == ST_ID) chk("ID_ALUSrcB", 32'(bus.ALUSrcB), 3);
      if (s.st == ST_EXR) chk("EXR_srcA", 32'(bus.ALUSrcA), 1);
      if (s.st == ST_WBR) begin
        chk("WBR_RegDst", 32'(bus.RegDst), 1);
        chk("WBR_MemtoReg", 32'(bus.MemtoReg), 0);
      end
      if (s.st == ST_WBL) chk("WBL_MemtoReg", 32'(bus.MemtoReg), 1);
      if (s.st == ST_WBI) chk("WBI_MemtoReg", 32'(bus.MemtoReg), (op == 6'h0f) ? 2 : 0);
      if (s.st == ST_BR)  chk("BR_PCSource", 32'(bus.PCSource), 1);
      if (s.st == ST_J)   chk("J_PCSource", 32'(bus.PCSource), 2);
      if (s.st == ST_INT) chk("INT_PCSource", 32'(bus.PCSource), 3);
      if (bus.mem_w === 1'b1) mw_seen++;
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int if_st, input int mem_st);
    build(op, fn, z, if_st, mem_st);
    run_q(op, fn, z, exp_q.size());
  endtask

  initial begin
    logic [5:0] ops [13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08,
                             6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h00};
    logic [5:0] fns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00};
    step_t s;

    // Reset state with strobes masked even though MIO_ready=1 would fetch.
    reset = 1'b1; bus.opcode = 6'h00; bus.func = 6'h00; bus.zero = 1'b0;
    bus.MIO_ready = 1'b1; bus.INT = 1'b0;
    @(negedge clk); #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_IRWrite", 32'(bus.IRWrite), 0);
    chk("rst_PC_en", 32'(bus.PC_en), 0);
    chk("rst_mem_r", 32'(bus.mem_r), 0);
    chk("rst_CPU_MIO", 32'(bus.CPU_MIO), 0);
    @(posedge clk); #2 reset = 1'b0;

    // Directed instructions.
    instr(6'h00, 6'h20, 1'b0, 0, 0);           // add 01CE5020
    instr(6'h23, 6'h03, 1'b0, 0, 3);           // lw with 3-cycle stall
    mw_seen = 0;
    instr(6'h2b, 6'h08, 1'b0, 0, 3);           // sw with 3-cycle stall
    chk("sw_mem_w_cycles", mw_seen, 4);
    instr(6'h04, 6'h00, 1'b1, 0, 0);           // beq taken
    instr(6'h05, 6'h00, 1'b1, 0, 0);           // bne not taken
    instr(6'h02, 6'h02, 1'b0, 0, 0);           // j 08000002
    instr(6'h00, 6'h2a, 1'b0, 0, 0);           // slt 0100782A
    instr(6'h0c, 6'h05, 1'b0, 1, 0);           // andi with IF stall
    instr(6'h0f, 6'h00, 1'b0, 0, 0);           // lui
    instr(6'h00, 6'h3f, 1'b0, 0, 0);           // unknown func: no write
    instr(6'h3c, 6'h00, 1'b0, 0, 0);           // unknown opcode: nop

    // Reset while a lw is stalled in MRD.
    build(6'h23, 6'h03, 1'b0, 0, 5);
    run_q(6'h23, 6'h03, 1'b0, 4);
    #1 reset = 1'b1;
    #1;
    chk("midrst_state", 32'(bus.state), 0);
    chk("midrst_RegWrite", 32'(bus.RegWrite), 0);
    chk("midrst_mem_r", 32'(bus.mem_r), 0);
    @(posedge clk); #2 reset = 1'b0;
    instr(6'h00, 6'h22, 1'b0, 0, 0);           // fetch resumes

    // INT during EXR, then a second edge during the INT cycle.
    build(6'h00, 6'h20, 1'b0, 0, 0);
    exp_q[2].intv = 1'b1;
    exp_q.push_back(mk(ST_IF, 2));
    s = mk(ST_INT, 2); s.pce = 1; s.epc = 1; s.intv = 1'b1; exp_q.push_back(s);
    exp_q.push_back(mk(ST_IF, 2));
    s = mk(ST_INT, 2); s.pce = 1; s.epc = 1; exp_q.push_back(s);
    run_q(6'h00, 6'h20, 1'b0, exp_q.size());
    instr(6'h00, 6'h25, 1'b0, 0, 0);           // normal fetch afterwards

    // Randomised instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge clk); #1;
    chk("end_state", 32'(bus.state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
Multi-cycle control FSM that sequences the shared SCPU datapath (single ALU, single memory port) over IF/ID/EX/MEM/WB steps.
Decodes the opcode and func fields from the external IR and emits every datapath mux select and write enable.
Stretches memory states on MIO_ready and services edge-triggered INT requests between instructions.
Sits beside the datapath inside the multi-cycle CPU top; CPU_MIO and mem_w come from here.

Parameters:
WAIT_MEM, 1, 1 = memory states stall while MIO_ready=0; 0 = MIO_ready is ignored (treated as 1).
INT_ENABLE, 1, 1 = INT servicing on; 0 = INT ignored and the pending flag is held at 0.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
MIO_ready  in  1  memory/IO access complete
INT  in  1  interrupt request, rising-edge sensitive
PC_en  out  1  PC write enable (already includes branch qualification)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_r  out  1  memory read
mem_w  out  1  memory write
CPU_MIO  out  1  memory/IO cycle active (mem_r | mem_w)
IRWrite  out  1  IR load
RegWrite  out  1  register file write
RegDst  out  2  00 = rt, 01 = rd
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = {imm,16'h0}
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2
ExtSel  out  1  0 = sign-extend, 1 = zero-extend
ALU_Control  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = interrupt vector
EPCWrite  out  1  EPC <= PC
state  out  4  current state, for debug

Behaviour:
- Reset: state = IF, pending = 0, INT edge register = 0. While reset is high, PC_en, IRWrite, RegWrite, mem_w, mem_r and EPCWrite are forced to 0.
- Outputs are Moore (decoded from state), except three qualified terms:
  - ALU_Control in EXR/EXI is decoded from func/opcode.
  - PC_en in BR = (zero ^ (opcode==bne)).
  - IRWrite/PC_en in IF = MIO_ready.
- Any output not listed for a state is 0.
- Default ALU_Control is ADD.
- State encodings: IF=0, ID=1, MA=2, MRD=3, WBL=4, MWR=5, EXR=6, WBR=7, BR=8, J=9, EXI=10, WBI=11, INT=13.
- IF:
  - If pending=1, go to INT with no fetch.
  - Otherwise: mem_r=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00, IRWrite=PC_en=MIO_ready.
  - Stay in IF while MIO_ready=0; else go to ID.
- ID: ALUSrcA=0, ALUSrcB=11 (branch target to ALUOut). Next state by opcode:
  - 000000 → EXR
  - 100011/101011 (lw/sw) → MA
  - 000100/000101 (beq/bne) → BR
  - 000010 → J
  - 001000/001010/001100/001101/001110 → EXI
  - 001111 (lui) → WBI
  - any other opcode → IF (executes as nop)
- MA: ALUSrcA=1, ALUSrcB=10, ExtSel=0. lw → MRD, sw → MWR.
- MRD: mem_r=1, IorD=1. Hold while MIO_ready=0, then → WBL.
- WBL: RegDst=00, MemtoReg=01, RegWrite=1 → IF.
- MWR: mem_w=1, IorD=1, held for the whole stall. → IF when MIO_ready=1.
- EXR: ALUSrcA=1, ALUSrcB=00. func map:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - Known func → WBR. Unknown func → IF with no write.
- WBR: RegDst=01, MemtoReg=00, RegWrite=1 → IF.
- BR: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PC_en qualified as above → IF.
- J: PCSource=10, PC_en=1 → IF.
- EXI: ALUSrcA=1, ALUSrcB=10 → WBI.
  - addi: ADD, ExtSel=0.
  - slti: SLT, ExtSel=0.
  - andi/ori/xori: AND/OR/XOR, ExtSel=1.
- WBI: RegDst=00, RegWrite=1 → IF. MemtoReg=10 for lui, 00 otherwise.
- INT: EPCWrite=1, PCSource=11, PC_en=1, pending cleared → IF.
- Interrupts:
  - pending is set on a sampled rising edge of INT in any state.
  - A set in the same cycle as a clear (state INT) wins, so the request is not lost.
  - An interrupt is taken only on IF entry, never mid-instruction.
- Cycle counts with no stalls: R-type/imm 4, lw 5, sw 4, branch 3, j 3. Each MIO_ready=0 cycle adds 1.
- Reset asserted mid-instruction: immediate return to IF; the partial instruction produces no writes.

Decomposition:
- Shared package mcpu_defs: state encodings, opcode/func constants, ALU_Control codes, mux-select encodings. The datapath uses the same package.
- Sub-module mcpu_alu_dec: combinational decoder (opcode, func, state class → ALU_Control, ExtSel, func_valid).
- The FSM, the INT edge detector and the pending flag stay in mcpu_ctrl.

Test Plan:
- Reset pulsed while in MRD (lw 8D0A0003 in flight) → state=0 asynchronously, RegWrite never asserted, fetch resumes after release.
- add 01CE5020 → states 0,1,6,7,0; in EXR ALU_Control=010; in WBR RegWrite=1, RegDst=01.
- lw 8D0A0003 with MIO_ready low for 3 cycles in MRD → 8 cycles total. sw AD0C0008 with the same stall → mem_w=1 for 4 consecutive cycles.
- beq with zero=1 → PC_en=1, PCSource=01. bne with zero=1 → PC_en=0. Both take 3 cycles.
- j 08000002 → states 0,1,9; PCSource=10, PC_en=1. slt 0100782A → ALU_Control=111. andi → ExtSel=1.
- INT pulse during EXR → WBR completes, then INT state with EPCWrite=1, PCSource=11. A second pulse in that INT cycle → INT taken again after the next IF entry.
